seq_mag_comparator: RTL
=======================

// Module: seq_mag_comparator
// PURPOSE
//  Multi-cycle N-bit magnitude comparator with a start/done handshake. It compares W bits per clock, MSB chunk first.
//  It stops early on the first chunk that differs. The compare is signed or unsigned, selected per operation.
//  Successor to the combinational n-bit magnitude comparator. Intended for wide operands (64+ bits) where a flat compare misses timing.
// PARAMETERS
//  N   32  operand width in bits; must be an integer multiple of W
//  W   8   chunk width compared per cycle; 1 <= W <= N
// PORTS
//  clk          in   1  single clock; all logic on posedge
//  rst          in   1  synchronous, active-high reset
//  start        in   1  request a compare; sampled on posedge
//  signed_mode  in   1  1 = two's-complement compare, 0 = unsigned; sampled with start
//  A            in   N  operand A; sampled with start
//  B            in   N  operand B; sampled with start
//  busy         out  1  high while a compare is in progress
//  done         out  1  one-cycle pulse: L_T/G_T/E are valid
//  L_T          out  1  A < B
//  G_T          out  1  A > B
//  E            out  1  A == B
//  n_chunks     out  clog2(N/W+1)  chunks examined in the last compare (1..N/W)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, L_T, G_T, E all 0; n_chunks=0. Reset mid-compare abandons the operation; no done pulse.
//  - Constant NCH = N/W.
//  - FSM IDLE -> CMP -> DONE.
//    - IDLE/DONE, start=1: latch A, B and signed_mode; set idx=NCH-1; clear L_T/G_T/E; go to CMP with busy=1.
//    - IDLE, start=0: stay in IDLE. DONE, start=0: go to IDLE.
//  - CMP, each cycle: compare chunk idx of A with chunk idx of B, unsigned.
//    - When idx==NCH-1 and signed_mode=1, invert bit N-1 of both operands before the compare (sign fix).
//    - Chunks differ: set L_T or G_T, write n_chunks=NCH-idx, go to DONE.
//    - Chunks equal, idx==0: set E=1, write n_chunks=NCH, go to DONE.
//    - Chunks equal, idx>0: decrement idx and stay in CMP.
//  - DONE: done=1 and busy=0 for exactly one cycle. Back-to-back start is accepted in DONE, so there are no idle cycles between ops.
//  - Latency: accepting edge t, then the result registered at edge t+k, where k = chunks examined. done is high in the cycle after t+k.
//    Best case k=1; worst case k=NCH (equal operands, or difference only in chunk 0).
//  - L_T/G_T/E/n_chunks hold their values until the next accepted start. Exactly one of L_T/G_T/E is high after any completed op.
//  - start while busy (CMP) is ignored. Inputs change freely after the accepting edge.
//  - W==N degenerates to a 1-cycle compare and must still work.
// STRUCTURE
//  - Shared package/header cmp_pkg:
//    - state encodings S_IDLE=2'd0, S_CMP=2'd1, S_DONE=2'd2
//    - clog2 function
//    - NCH derivation and the N%W==0 elaboration check
//  - One sub-module, chunk_cmp #(W): purely combinational W-bit unsigned compare, giving lt, gt, eq. Instantiate it once.
//  - Top level: FSM, operand registers, the idx counter, chunk mux with the sign-bit fix, and the result registers.
// TESTING  (N=12, W=4, NCH=3)
//  1. unsigned A=12'hF0C, B=12'hF0D -> after 3 chunks L_T=1 G_T=0 E=0, n_chunks=3, done 3 cycles after accept
//  2. unsigned A=12'hAAA, B=12'hAAA -> E=1, n_chunks=3; A=12'hFFF, B=12'h9E7 -> G_T=1, n_chunks=1, done 1 cycle after accept
//  3. A=12'h800, B=12'h001: signed -> L_T=1 (-2048<1); unsigned -> G_T=1; both n_chunks=1
//  4. A=12'h123, B=12'h456 start; at the next edge start with A=B=0 -> second start ignored; result L_T=1, n_chunks=1
//  5. Start A=12'h555, B=12'h554; assert rst at the 2nd CMP cycle -> no done, all outputs 0, busy=0; a new start then completes normally
//  6. Start held high continuously over 4 random ops -> each op accepted in DONE; results match a golden compare; exactly one flag set each time

Source files
------------

// File: rtl/seq_mag_comparator_pkg.sv
// Shared definitions for the chunked magnitude comparator: state encodings,
// width helpers and the operand/chunk geometry check.
package seq_mag_comparator_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned nch(input int unsigned n, input int unsigned w);
    return n / w;
  endfunction

  function automatic bit geometry_ok(input int unsigned n, input int unsigned w);
    return (w >= 1) && (w <= n) && ((n % w) == 0);
  endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Start/done handshake, operands and result flags of the sequential comparator.
interface seq_mag_comparator_if
  import seq_mag_comparator_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) ();

  localparam int unsigned CW = clog2(N / W + 1);

  logic          start;
  logic          signed_mode;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          busy;
  logic          done;
  logic          L_T;
  logic          G_T;
  logic          E;
  logic [CW-1:0] n_chunks;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, L_T, G_T, E, n_chunks
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, L_T, G_T, E, n_chunks
  );

endinterface

// File: rtl/seq_mag_comparator_chunk_cmp.sv
// Combinational W-bit unsigned compare of one operand chunk.
module chunk_cmp #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         gt,
  output logic         eq
);

  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle N-bit magnitude comparator: walks W-bit chunks MSB first and
// stops on the first chunk that differs; signed or unsigned per operation.
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input logic               clk,
  input logic               rst,
  seq_mag_comparator_if.slave bus
);

  localparam int unsigned NCH = nch(N, W);
  localparam int unsigned IW  = (NCH > 1) ? clog2(NCH) : 1;
  localparam int unsigned CW  = clog2(NCH + 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(NCH - 1);

  if (!geometry_ok(N, W)) begin : g_bad_geometry
    $error("seq_mag_comparator: N must be a non-zero multiple of W");
  end

  logic [1:0]    state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          sm_q;
  logic [IW-1:0] idx;

  logic          l_t_q;
  logic          g_t_q;
  logic          e_q;
  logic [CW-1:0] n_q;

  logic [N-1:0]  a_fix;
  logic [N-1:0]  b_fix;
  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic          c_lt;
  logic          c_gt;
  logic          c_eq;
  logic          accept;

  // Flipping both sign bits maps two's-complement order onto unsigned order,
  // so only the top chunk needs the fix and the chunk compare stays unsigned.
  always_comb begin
    a_fix = a_q;
    b_fix = b_q;
    if (sm_q && (idx == IDX_TOP)) begin
      a_fix[N-1] = ~a_q[N-1];
      b_fix[N-1] = ~b_q[N-1];
    end
    a_chunk = a_fix[idx*W +: W];
    b_chunk = b_fix[idx*W +: W];
  end

  chunk_cmp #(.W(W)) u_chunk_cmp (
    .a  (a_chunk),
    .b  (b_chunk),
    .lt (c_lt),
    .gt (c_gt),
    .eq (c_eq)
  );

  assign accept = bus.start && (state != S_CMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
      idx   <= '0;
      l_t_q <= 1'b0;
      g_t_q <= 1'b0;
      e_q   <= 1'b0;
      n_q   <= '0;
    end else if (accept) begin
      state <= S_CMP;
      a_q   <= bus.A;
      b_q   <= bus.B;
      sm_q  <= bus.signed_mode;
      idx   <= IDX_TOP;
      l_t_q <= 1'b0;
      g_t_q <= 1'b0;
      e_q   <= 1'b0;
    end else begin
      case (state)
        S_CMP: begin
          if (!c_eq) begin
            l_t_q <= c_lt;
            g_t_q <= c_gt;
            n_q   <= CW'(NCH) - CW'(idx);
            state <= S_DONE;
          end else if (idx == '0) begin
            e_q   <= 1'b1;
            n_q   <= CW'(NCH);
            state <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_CMP);
  assign bus.done     = (state == S_DONE);
  assign bus.L_T      = l_t_q;
  assign bus.G_T      = g_t_q;
  assign bus.E        = e_q;
  assign bus.n_chunks = n_q;

endmodule
